// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: state
// encoding, default geometry and configuration checks usable at elaboration.
package bin2bcd_seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DIGITS = 3;
    localparam int DEF_CNTW   = 4;

    // True when DIGITS decimal digits can hold every WIDTH-bit unsigned value.
    function automatic bit digits_ok(input int w, input int d);
        longint lim;
        longint p;
        lim = (longint'(1) << w) - 1;
        p   = 1;
        for (int k = 0; k < d; k++) begin
            p = p * 10;
        end
        return p > lim;
    endfunction

    // True when a CNTW-bit counter can be loaded with WIDTH.
    function automatic bit cntw_ok(input int cw, input int w);
        return (longint'(1) << cw) > longint'(w);
    endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that the
// following left shift carries into the next decimal digit. Purely combinational.
module bcd_add3_4bit (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    // Add 3 (mod 16) when the digit is 5..15, otherwise pass through.
    always_comb begin
        d_o = d_i;
        if (d_i >= 4'd5) begin
            d_o = d_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter. One double-dabble iteration (correct,
// then shift) per clock over a {bcd, bin} shift register.
//
// Handshake: start is sampled only while busy is low; the operand on in is
// captured on that same edge. busy is high for WIDTH cycles, then valid pulses
// for one cycle with the result on out. out holds until the next result or
// reset. A start in the valid cycle is accepted, so conversions can run
// back-to-back every WIDTH+1 cycles.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS,
    parameter int CNTW   = DEF_CNTW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      in,
    output logic [4*DIGITS-1:0]   out,
    output logic                  busy,
    output logic                  valid
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = WIDTH + BW;

    // Configuration checks: a geometry that cannot represent the input range
    // or count the iterations is rejected while elaborating.
    if (!digits_ok(WIDTH, DIGITS)) begin : g_digits_err
        $error("bin2bcd_seq: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
    end
    if (!cntw_ok(CNTW, WIDTH)) begin : g_cntw_err
        $error("bin2bcd_seq: CNTW=%0d too small for WIDTH=%0d", CNTW, WIDTH);
    end

    state_t             state_q, state_d;
    logic [SW-1:0]      sr_q, sr_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]      out_q, out_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;

    logic [BW-1:0]      bcd_corr;
    logic [SW-1:0]      sr_shifted;

    // One add-3 corrector per BCD digit of the accumulator.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3_4bit u_add3 (
            .d_i (sr_q[WIDTH + 4*g +: 4]),
            .d_o (bcd_corr[4*g +: 4])
        );
    end

    // Corrected accumulator joined with the remaining binary bits, shifted left;
    // the binary MSB lands in bcd bit 0.
    assign sr_shifted = {bcd_corr, sr_q[WIDTH-1:0]} << 1;

    // Next-state and output logic for the IDLE/SHIFT sequencer.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = {{BW{1'b0}}, in};
                    cnt_d   = CNTW'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = sr_shifted;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNTW'(1)) begin
                    out_d   = sr_shifted[SW-1:WIDTH];
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; synchronous reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign out   = out_q;
    assign busy  = busy_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed vector table, multi-cycle corner sequences,
// random operands and an exhaustive back-to-back sweep, all checked against a
// decimal-arithmetic reference.
module tb_bin2bcd_seq;
    import bin2bcd_seq_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int D  = DEF_DIGITS;
    localparam int BW = 4 * D;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  bin_in;
    logic [BW-1:0] out;
    logic          busy;
    logic          valid;

    int tests;
    int fails;

    bin2bcd_seq #(.WIDTH(W), .DIGITS(D), .CNTW(DEF_CNTW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (bin_in),
        .out   (out),
        .busy  (busy),
        .valid (valid)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by division, least significant digit first.
    function automatic logic [BW-1:0] ref_bcd(input int unsigned v);
        logic [BW-1:0] r;
        r = '0;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // BCD back to binary, for the loop-back check.
    function automatic int unsigned bcd_to_bin(input logic [BW-1:0] b);
        int unsigned s;
        s = 0;
        for (int k = D - 1; k >= 0; k--) begin
            s = s * 10 + int'(b[4*k +: 4]);
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; leaves us at the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One conversion with a one-cycle start pulse; checks exact latency,
    // busy span, single-cycle valid and result hold.
    task automatic run_conv(input string name, input logic [W-1:0] v, input logic [BW-1:0] exp);
        bit lat_ok;
        bin_in = v;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        lat_ok = (busy === 1'b1) && (valid === 1'b0);
        for (int n = 1; n < W; n++) begin
            tick();
            if (!((busy === 1'b1) && (valid === 1'b0))) lat_ok = 1'b0;
        end
        tick();
        check({name, "_busy_span"}, 32'(lat_ok), 32'd1);
        check({name, "_valid"}, 32'(valid), 32'd1);
        check({name, "_busy_done"}, 32'(busy), 32'd0);
        check({name, "_out"}, 32'(out), 32'(exp));
        tick();
        check({name, "_valid_1cyc"}, 32'(valid), 32'd0);
        check({name, "_out_hold"}, 32'(out), 32'(exp));
    endtask

    // Wait for valid with a cycle budget.
    task automatic wait_valid(input int budget, output int cycles, output bit ok);
        ok     = 1'b0;
        cycles = 0;
        while (cycles < budget && !ok) begin
            tick();
            cycles++;
            if (valid === 1'b1) ok = 1'b1;
        end
    endtask

    typedef struct {
        logic [W-1:0]  in_v;
        logic [BW-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int  cyc;
        bit  ok;
        int  nvalid;
        logic [W-1:0] rv;

        tests  = 0;
        fails  = 0;
        rst    = 1'b0;
        start  = 1'b0;
        bin_in = '0;

        vecs[0] = '{8'd0,   12'h000};
        vecs[1] = '{8'd99,  12'h099};
        vecs[2] = '{8'd255, 12'h255};
        vecs[3] = '{8'd128, 12'h128};
        vecs[4] = '{8'd1,   12'h001};
        vecs[5] = '{8'd9,   12'h009};
        vecs[6] = '{8'd10,  12'h010};
        vecs[7] = '{8'd100, 12'h100};
        vecs[8] = '{8'd199, 12'h199};
        vecs[9] = '{8'd64,  12'h064};

        @(negedge clk);
        do_reset();
        check("reset_out", 32'(out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i].in_v, vecs[i].exp);
        end

        // Start while busy is ignored: 42 then 7 three cycles later.
        bin_in = 8'd42;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        bin_in = 8'd7;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        bin_in = '0;
        nvalid = 0;
        for (int n = 0; n < 3 * W; n++) begin
            if (valid === 1'b1) nvalid++;
            tick();
        end
        check("busy_start_valid_count", 32'(nvalid), 32'd1);
        check("busy_start_out", 32'(out), 32'h042);

        // Reset in the middle of a conversion aborts it.
        bin_in = 8'd200;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        tick();
        do_reset();
        check("abort_out", 32'(out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        nvalid = 0;
        for (int n = 0; n < 2 * W; n++) begin
            tick();
            if (valid === 1'b1) nvalid++;
        end
        check("abort_no_valid", 32'(nvalid), 32'd0);
        run_conv("after_abort", 8'd15, 12'h015);

        // Random operands against the reference.
        for (int i = 0; i < 24; i++) begin
            rv = W'($urandom_range(0, (1 << W) - 1));
            run_conv($sformatf("rand%0d_%0d", i, rv), rv, ref_bcd(int'(rv)));
        end

        // Exhaustive sweep with start held high: each valid cycle accepts the next.
        bin_in = '0;
        start  = 1'b1;
        for (int i = 0; i < (1 << W); i++) begin
            wait_valid(2 * W + 4, cyc, ok);
            if (!ok) begin
                check($sformatf("sweep%0d_timeout", i), 32'd0, 32'd1);
                break;
            end
            check($sformatf("sweep%0d_out", i), 32'(out), 32'(ref_bcd(i)));
            if (i > 0) check($sformatf("sweep%0d_spacing", i), 32'(cyc), 32'(W + 1));
            if (i < 100) check($sformatf("sweep%0d_loopback", i), bcd_to_bin(out), 32'(i));
            if (i < (1 << W) - 1) bin_in = W'(i + 1);
            else start = 1'b0;
        end
        start = 1'b0;
        tick();
        check("sweep_end_valid", 32'(valid), 32'd0);
        check("sweep_end_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
